// File: rtl/calc_pkg.sv
// Shared opcodes and FSM state encoding for the calculator sequencer.
// CALC_SEQ_MUL_EN turns opcode 111 from NOP into MUL.
package calc_pkg;

    localparam logic [2:0] OP_LDI  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

    // True when the opcode produces a write-back and result pulse.
    function automatic logic op_writes(input logic [2:0] op);
`ifdef CALC_SEQ_MUL_EN
        return (op == OP_MUL) || (op != OP_MUL);
`else
        return op != OP_NOP;
`endif
    endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational ALU for the sequencer: result and carry/borrow per opcode.
// With CALC_SEQ_MUL_EN defined, opcode 111 multiplies; otherwise no multiplier exists.
module calc_alu
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] imm_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    // MSB of the widened difference is the unsigned borrow (A < B).
    assign diff = {1'b0, a_i} - {1'b0, b_i};

`ifdef CALC_SEQ_MUL_EN
    logic [2*WIDTH-1:0] prod;
    assign prod = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
`endif

    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        case (op_i)
            OP_LDI:  result_o = imm_i;
            OP_ADD: begin
                result_o = sum[WIDTH-1:0];
                carry_o  = sum[WIDTH];
            end
            OP_SUB: begin
                result_o = diff[WIDTH-1:0];
                carry_o  = diff[WIDTH];
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_SLTU: result_o = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
            default: begin
`ifdef CALC_SEQ_MUL_EN
                result_o = prod[WIDTH-1:0];
                carry_o  = |prod[2*WIDTH-1:WIDTH];
`endif
            end
        endcase
    end

endmodule

// File: rtl/calc_sequencer.sv
// Four-state command sequencer: accept, read register file, execute, write back.
// Opcode 111 is MUL when CALC_SEQ_MUL_EN is defined, otherwise a NOP.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [REGBITS-1:0] cmd_dst,
    input  logic [REGBITS-1:0] cmd_srca,
    input  logic [REGBITS-1:0] cmd_srcb,
    input  logic [WIDTH-1:0]   cmd_imm,
    output logic [REGBITS-1:0] ra1,
    output logic [REGBITS-1:0] ra2,
    input  logic [WIDTH-1:0]   rd1,
    input  logic [WIDTH-1:0]   rd2,
    output logic               regwrite,
    output logic [REGBITS-1:0] wa,
    output logic [WIDTH-1:0]   wd,
    output logic               res_valid,
    output logic [WIDTH-1:0]   res_data,
    output logic               flag_z,
    output logic               flag_c
);

    state_e               state_q, state_d;
    logic [2:0]           op_q;
    logic [REGBITS-1:0]   dst_q, ra1_q, ra2_q, wa_q;
    logic [WIDTH-1:0]     imm_q, opa_q, opb_q, res_q;
    logic                 flag_z_q, flag_c_q;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_carry;
    logic                 accept;
    logic                 exec_writes;

    calc_alu #(.WIDTH(WIDTH)) u_alu (
        .op_i     (op_q),
        .a_i      (opa_q),
        .b_i      (opb_q),
        .imm_i    (imm_q),
        .result_o (alu_res),
        .carry_o  (alu_carry)
    );

    assign accept      = cmd_valid && cmd_ready;
    assign exec_writes = op_writes(op_q);

    // regwrite decodes straight from state so an async reset kills it at once.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        regwrite  = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = S_READ;
            end
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = exec_writes ? S_WRITE : S_IDLE;
            S_WRITE: begin
                regwrite  = 1'b1;
                res_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            dst_q    <= '0;
            ra1_q    <= '0;
            ra2_q    <= '0;
            imm_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            res_q    <= '0;
            wa_q     <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= cmd_op;
                dst_q <= cmd_dst;
                ra1_q <= cmd_srca;
                ra2_q <= cmd_srcb;
                imm_q <= cmd_imm;
            end
            if (state_q == S_READ) begin
                opa_q <= rd1;
                opb_q <= rd2;
            end
            if (state_q == S_EXEC && exec_writes) begin
                res_q    <= alu_res;
                wa_q     <= dst_q;
                flag_z_q <= (alu_res == '0);
                flag_c_q <= alu_carry;
            end
        end
    end

    assign ra1      = ra1_q;
    assign ra2      = ra2_q;
    assign wa       = wa_q;
    assign wd       = res_q;
    assign res_data = res_q;
    assign flag_z   = flag_z_q;
    assign flag_c   = flag_c_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: register file environment, a cycle-level
// reference model checked every cycle, directed literal checks and random commands.
module tb_calc_sequencer;

    localparam int W  = 8;
    localparam int RB = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [RB-1:0] cmd_dst = '0, cmd_srca = '0, cmd_srcb = '0;
    logic [W-1:0]  cmd_imm = '0;
    logic [RB-1:0] ra1, ra2, wa;
    logic [W-1:0]  rd1, rd2, wd, res_data;
    logic          regwrite, res_valid, flag_z, flag_c;

    calc_sequencer #(.WIDTH(W), .REGBITS(RB)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb), .cmd_imm(cmd_imm),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .regwrite(regwrite), .wa(wa), .wd(wd),
        .res_valid(res_valid), .res_data(res_data), .flag_z(flag_z), .flag_c(flag_c)
    );

    always #5 clk = ~clk;

    // Register file environment: r0 is never written so it always reads zero.
    logic [W-1:0] rf [8] = '{default: '0};
    assign rd1 = rf[ra1];
    assign rd2 = rf[ra2];
    always @(posedge clk) if (regwrite && wa != '0) rf[wa] <= wd;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic from the opcode table, using plain integers.
    function automatic void ref_calc(input int op, input int a, input int b, input int imm,
                                     output int r, output int c, output bit wr);
        int m;
        m  = 1 << W;
        wr = 1'b1;
        c  = 0;
        r  = 0;
        case (op)
            0: r = imm;
            1: begin r = (a + b) % m; c = ((a + b) >= m) ? 1 : 0; end
            2: begin r = (a - b + m) % m; c = (a < b) ? 1 : 0; end
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = (a < b) ? 1 : 0;
            default: begin
`ifdef CALC_SEQ_MUL_EN
                r = (a * b) % m;
                c = ((a * b) >= m) ? 1 : 0;
`else
                wr = 1'b0;
`endif
            end
        endcase
    endfunction

    // Model state: cycles left until idle, pending command, held output values.
    int mrf [8] = '{default: 0};
    int cnt = 0;
    bit first = 1'b0, cur_wr = 1'b0;
    int cur_dst = 0, cur_res = 0, cur_c = 0, cur_sa = 0, cur_sb = 0;
    int m_wa = 0, m_res = 0, m_z = 0, m_c = 0, m_ra1 = 0, m_ra2 = 0;

    always @(negedge clk) begin
        int a, b, r, c;
        bit wr;
        if (!rst_n) begin
            cnt = 0; first = 1'b0; cur_wr = 1'b0;
            m_wa = 0; m_res = 0; m_z = 0; m_c = 0; m_ra1 = 0; m_ra2 = 0;
        end else begin
            if (first) begin
                m_ra1 = cur_sa;
                m_ra2 = cur_sb;
                first = 1'b0;
            end
            if (cnt == 1 && cur_wr) begin
                m_wa = cur_dst; m_res = cur_res;
                m_z = (cur_res == 0) ? 1 : 0; m_c = cur_c;
            end
        end
        chk("cmd_ready", 32'(cmd_ready), 32'(cnt == 0));
        chk("regwrite", 32'(regwrite), 32'(cnt == 1 && cur_wr));
        chk("res_valid", 32'(res_valid), 32'(cnt == 1 && cur_wr));
        chk("wa", 32'(wa), m_wa);
        chk("wd", 32'(wd), m_res);
        chk("res_data", 32'(res_data), m_res);
        chk("flag_z", 32'(flag_z), m_z);
        chk("flag_c", 32'(flag_c), m_c);
        chk("ra1", 32'(ra1), m_ra1);
        chk("ra2", 32'(ra2), m_ra2);
        if (rst_n) begin
            if (cnt == 1 && cur_wr && cur_dst != 0) mrf[cur_dst] = cur_res;
            if (cnt > 0) begin
                cnt--;
            end else if (cmd_valid) begin
                a = mrf[cmd_srca];
                b = mrf[cmd_srcb];
                ref_calc(int'(cmd_op), a, b, int'(cmd_imm), r, c, wr);
                cur_sa = int'(cmd_srca); cur_sb = int'(cmd_srcb); cur_dst = int'(cmd_dst);
                cur_res = r; cur_c = c; cur_wr = wr;
                cnt = wr ? 3 : 2;
                first = 1'b1;
            end
        end
    end

    // Inputs change only at posedge+1, so the model samples stable values.
    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) begin
            total++; bad++;
            $display("FAIL ready_timeout actual=0 required=1 t=%0t", $time);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [RB-1:0] d, input logic [RB-1:0] sa,
                        input logic [RB-1:0] sb, input logic [W-1:0] imm);
        cmd_valid = 1'b1;
        cmd_op = op; cmd_dst = d; cmd_srca = sa; cmd_srcb = sb; cmd_imm = imm;
        wait_ready();
        @(posedge clk); #1;
        $display("cmd op=%0d dst=%0d srca=%0d srcb=%0d imm=%0h t=%0t", op, d, sa, sb, imm, $time);
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
        wait_ready();
    endtask

    initial begin
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_regwrite", 32'(regwrite), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        send(3'd0, 3'd3, 3'd0, 3'd0, 8'h2A); idle();
        chk("ldi_wd", 32'(wd), 32'h2A);
        chk("ldi_z", 32'(flag_z), 32'd0);
        chk("ldi_rf3", 32'(rf[3]), 32'h2A);

        send(3'd0, 3'd1, 3'd0, 3'd0, 8'hF0);
        send(3'd0, 3'd2, 3'd0, 3'd0, 8'h20);
        send(3'd1, 3'd4, 3'd1, 3'd2, 8'h00); idle();
        chk("add_wd", 32'(wd), 32'h10);
        chk("add_c", 32'(flag_c), 32'd1);
        send(3'd2, 3'd5, 3'd2, 3'd1, 8'h00); idle();
        chk("sub_wd", 32'(wd), 32'h30);
        chk("sub_c", 32'(flag_c), 32'd1);
        send(3'd5, 3'd6, 3'd1, 3'd1, 8'h00); idle();
        chk("xor_wd", 32'(wd), 32'h00);
        chk("xor_z", 32'(flag_z), 32'd1);
        send(3'd6, 3'd7, 3'd2, 3'd1, 8'h00); idle();
        chk("sltu_wd", 32'(wd), 32'h01);

        chk("model_r3", 32'(mrf[3]), 32'h2A);
        chk("model_r4", 32'(mrf[4]), 32'h10);
        chk("model_r5", 32'(mrf[5]), 32'h30);
        chk("model_r6", 32'(mrf[6]), 32'h00);
        chk("model_r7", 32'(mrf[7]), 32'h01);

        // Three commands queued with cmd_valid held high throughout.
        send(3'd0, 3'd1, 3'd0, 3'd0, 8'h10);
        send(3'd0, 3'd2, 3'd0, 3'd0, 8'h11);
        send(3'd7, 3'd0, 3'd1, 3'd2, 8'h00); idle();
`ifdef CALC_SEQ_MUL_EN
        chk("mul_wd", 32'(wd), 32'h10);
        chk("mul_c", 32'(flag_c), 32'd1);
`else
        chk("nop_wd_hold", 32'(wd), 32'h11);
        chk("nop_c_hold", 32'(flag_c), 32'd0);
`endif

        // Reset during the WRITE cycle of an ADD into r4.
        send(3'd1, 3'd4, 3'd2, 3'd2, 8'h00);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("wr_cycle_regwrite", 32'(regwrite), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_regwrite", 32'(regwrite), 32'd0);
        chk("async_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_rf4", 32'(rf[4]), 32'h10);

        repeat (60) begin
            send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) chk($sformatf("final_r%0d", i), 32'(rf[i]), mrf[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
